// File: rtl/eb_rr_arb.sv
// ============================================================================
// Module   : eb_rr_arb
// Purpose  : N-input round-robin arbiter feeding one registered elastic-buffer
//            write port. Optional packet lock enabled by EB_RR_ARB_LOCK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module eb_rr_arb #(
    parameter int N     = 4,
    parameter int W     = 32,
    parameter int NLOG2 = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     t_req,
    output logic [N-1:0]     t_ack,
    input  logic [N*W-1:0]   t_dat,
    input  logic [N-1:0]     t_last,
    output logic             i_0_req,
    input  logic             i_0_ack,
    output logic [W-1:0]     i_0_dat,
    output logic             i_0_last,
    output logic [NLOG2-1:0] i_0_sel
);

    localparam logic [NLOG2-1:0] C_LAST_IDX = NLOG2'(N - 1);
    localparam logic [NLOG2:0]   C_N_EXT    = (NLOG2 + 1)'(N);

    // Next index after v, with explicit wrap so non-power-of-2 N works.
    function automatic logic [NLOG2-1:0] f_inc(input logic [NLOG2-1:0] v);
        return (v == C_LAST_IDX) ? '0 : v + NLOG2'(1);
    endfunction

    logic [NLOG2-1:0] ptr_q, ptr_d;
    logic             req_q, req_d;
    logic [W-1:0]     dat_q, dat_d;
    logic             last_q, last_d;
    logic [NLOG2-1:0] sel_q, sel_d;

    logic             w_scan_found;
    logic [NLOG2-1:0] w_scan_g;
    logic             w_found;
    logic [NLOG2-1:0] w_g;
    logic             w_ld;
    logic             w_xfer;

    always_comb begin
        logic [NLOG2:0] v_sum;
        v_sum        = '0;
        w_scan_found = 1'b0;
        w_scan_g     = ptr_q;
        for (int i = 0; i < N; i++) begin
            v_sum = {1'b0, ptr_q} + (NLOG2 + 1)'(i);
            if (v_sum >= C_N_EXT) begin
                v_sum = v_sum - C_N_EXT;
            end
            if (!w_scan_found && t_req[v_sum[NLOG2-1:0]]) begin
                w_scan_found = 1'b1;
                w_scan_g     = v_sum[NLOG2-1:0];
            end
        end
    end

`ifdef EB_RR_ARB_LOCK_EN
    localparam logic [0:0] S_ARB    = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [NLOG2-1:0] lk_q, lk_d;

    // While locked the grant is pinned to the packet owner, even if it idles.
    always_comb begin
        if (state_q == S_LOCKED) begin
            w_g     = lk_q;
            w_found = t_req[lk_q];
        end else begin
            w_g     = w_scan_g;
            w_found = w_scan_found;
        end
    end

    always_comb begin
        state_d = state_q;
        lk_d    = lk_q;
        ptr_d   = ptr_q;
        if (w_xfer) begin
            if (state_q == S_ARB) begin
                ptr_d = f_inc(w_g);
                if (!t_last[w_g]) begin
                    state_d = S_LOCKED;
                    lk_d    = w_g;
                end
            end else if (t_last[lk_q]) begin
                state_d = S_ARB;
                ptr_d   = f_inc(lk_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_ARB;
            lk_q    <= '0;
        end else begin
            state_q <= state_d;
            lk_q    <= lk_d;
        end
    end
`else
    always_comb begin
        w_g     = w_scan_g;
        w_found = w_scan_found;
        ptr_d   = w_xfer ? f_inc(w_g) : ptr_q;
    end
`endif

    assign w_ld   = !req_q || i_0_ack;
    assign w_xfer = w_ld && w_found;

    always_comb begin
        t_ack = '0;
        if (w_xfer) begin
            t_ack[w_g] = 1'b1;
        end
    end

    always_comb begin
        req_d  = req_q;
        dat_d  = dat_q;
        last_d = last_q;
        sel_d  = sel_q;
        if (w_xfer) begin
            req_d  = 1'b1;
            dat_d  = t_dat[w_g*W +: W];
            last_d = t_last[w_g];
            sel_d  = w_g;
        end else if (req_q && i_0_ack) begin
            req_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q  <= '0;
            req_q  <= 1'b0;
            dat_q  <= '0;
            last_q <= 1'b0;
            sel_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            req_q  <= req_d;
            dat_q  <= dat_d;
            last_q <= last_d;
            sel_q  <= sel_d;
        end
    end

    assign i_0_req  = req_q;
    assign i_0_dat  = dat_q;
    assign i_0_last = last_q;
    assign i_0_sel  = sel_q;

endmodule

`default_nettype wire

// File: tb/tb_eb_rr_arb.sv
// ============================================================================
// Module   : tb_eb_rr_arb
// Purpose  : Directed scoreboard bench for eb_rr_arb (N=4, W=32).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_eb_rr_arb;

    localparam int N     = 4;
    localparam int W     = 32;
    localparam int NLOG2 = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     t_req;
    logic [N-1:0]     t_ack;
    logic [N*W-1:0]   t_dat;
    logic [N-1:0]     t_last;
    logic             i_0_req;
    logic             i_0_ack;
    logic [W-1:0]     i_0_dat;
    logic             i_0_last;
    logic [NLOG2-1:0] i_0_sel;

    always #5 clk = ~clk;

    eb_rr_arb #(.N(N), .W(W), .NLOG2(NLOG2)) dut (
        .clk      (clk),
        .reset    (reset),
        .t_req    (t_req),
        .t_ack    (t_ack),
        .t_dat    (t_dat),
        .t_last   (t_last),
        .i_0_req  (i_0_req),
        .i_0_ack  (i_0_ack),
        .i_0_dat  (i_0_dat),
        .i_0_last (i_0_last),
        .i_0_sel  (i_0_sel)
    );

    typedef struct packed {
        logic [W-1:0]     dat;
        logic             last;
        logic [NLOG2-1:0] sel;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_b;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs, check combinational ack (and optionally the
    // output register) mid-cycle, queue the beat the grant should produce.
    task automatic step(input string name, input logic rst, input logic [3:0] req,
                        input logic [3:0] last, input logic ack, input logic [3:0] exp_ack,
                        input int exp_v, input int exp_dat);
        reset   = rst;
        t_req   = req;
        t_last  = last;
        i_0_ack = ack;
        @(negedge clk);
        chk({name, ".ack"}, 32'(t_ack), 32'(exp_ack));
        if (exp_v >= 0)   chk({name, ".req"}, 32'(i_0_req), 32'(exp_v));
        if (exp_dat >= 0) chk({name, ".dat"}, i_0_dat, 32'(exp_dat));
        if (rst) begin
            exp_q.delete();
        end else begin
            for (int k = 0; k < N; k++) begin
                if (exp_ack[k]) exp_q.push_back('{dat: 32'(k + 1), last: last[k], sel: 2'(k)});
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && i_0_req && i_0_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon.unexpected actual=%0h required=none", i_0_dat);
            end else begin
                mon_b = exp_q.pop_front();
                chk("mon.dat",  i_0_dat,          mon_b.dat);
                chk("mon.last", 32'(i_0_last),    32'(mon_b.last));
                chk("mon.sel",  32'(i_0_sel),     32'(mon_b.sel));
            end
        end
    end

    initial begin
        reset   = 1'b1;
        t_req   = '0;
        t_last  = '0;
        i_0_ack = 1'b0;
        for (int k = 0; k < N; k++) t_dat[k*W +: W] = 32'(k + 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("idle.req", 32'(i_0_req), 32'd0);
            chk("idle.ack", 32'(t_ack),   32'd0);
            chk("idle.sel", 32'(i_0_sel), 32'd0);
            @(posedge clk);
            #1;
        end

        // Round robin, all requesting, continuous downstream ack
        step("rr0", 0, 4'hF, 4'hF, 1, 4'b0001, 0, -1);
        step("rr1", 0, 4'hF, 4'hF, 1, 4'b0010, 1, 1);
        step("rr2", 0, 4'hF, 4'hF, 1, 4'b0100, 1, 2);
        step("rr3", 0, 4'hF, 4'hF, 1, 4'b1000, 1, 3);
        step("rr4", 0, 4'hF, 4'hF, 1, 4'b0001, 1, 4);
        step("rr5", 0, 4'hF, 4'hF, 1, 4'b0010, 1, 1);
        step("rr_drain", 0, 4'h0, 4'hF, 1, 4'b0000, 1, 2);

        // Backpressure on requester 2
        step("bp_x0", 0, 4'b0100, 4'hF, 0, 4'b0100, 0, -1);
        for (int c = 0; c < 3; c++) step("bp_stall", 0, 4'b0100, 4'hF, 0, 4'b0000, 1, 3);
        step("bp_x1", 0, 4'b0100, 4'hF, 1, 4'b0100, 1, 3);
        step("bp_drain", 0, 4'h0, 4'hF, 1, 4'b0000, 1, 3);

        // Single requester then wrap from 3 to 0
        step("wrap1", 0, 4'b0010, 4'hF, 1, 4'b0010, 0, -1);
        step("wrap3", 0, 4'b1001, 4'hF, 1, 4'b1000, 1, 2);
        step("wrap0", 0, 4'b1001, 4'hF, 1, 4'b0001, 1, 4);
        step("wrap_drain", 0, 4'h0, 4'hF, 1, 4'b0000, 1, 1);

        // Multi-beat packet from requester 1 with competitors 0 and 3
`ifdef EB_RR_ARB_LOCK_EN
        step("pk0", 0, 4'b1011, 4'b0000, 1, 4'b0010, -1, -1);
        step("pk1", 0, 4'b1001, 4'b0000, 1, 4'b0000, -1, -1);
        step("pk2", 0, 4'b1001, 4'b0000, 1, 4'b0000, -1, -1);
        step("pk3", 0, 4'b1011, 4'b0000, 1, 4'b0010, -1, -1);
        step("pk4", 0, 4'b1011, 4'b0010, 1, 4'b0010, -1, -1);
        step("pk5", 0, 4'b1001, 4'hF,    1, 4'b1000, -1, -1);
`else
        step("pk0", 0, 4'b1011, 4'b0000, 1, 4'b0010, -1, -1);
        step("pk1", 0, 4'b1001, 4'b0000, 1, 4'b1000, -1, -1);
        step("pk2", 0, 4'b1001, 4'b0000, 1, 4'b0001, -1, -1);
        step("pk3", 0, 4'b1011, 4'b0000, 1, 4'b0010, -1, -1);
        step("pk4", 0, 4'b1011, 4'b0010, 1, 4'b1000, -1, -1);
        step("pk5", 0, 4'b1001, 4'hF,    1, 4'b0001, -1, -1);
`endif
        step("pk_drain", 0, 4'h0, 4'hF, 1, 4'b0000, -1, -1);

        // Reset while a beat is buffered (and locked when the feature is on)
        step("rst_a", 0, 4'b0010, 4'b0000, 0, 4'b0010, 0, -1);
        step("rst_b", 1, 4'b0000, 4'b0000, 0, 4'b0000, 1, 2);
        step("rst_c", 0, 4'b0100, 4'hF,    1, 4'b0100, 0, -1);
        step("rst_d", 0, 4'b0000, 4'hF,    1, 4'b0000, 1, 3);

        step("end_idle", 0, 4'b0000, 4'h0, 1, 4'b0000, 0, -1);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
